// File: rtl/delay_ram_player_pkg.sv
// Shared types and default sizing for the delay RAM player.
`timescale 1ns/1ps
package delay_ram_player_pkg;
  localparam int unsigned ADDR_W_DEF  = 11;
  localparam int unsigned DELAY_W_DEF = 24;
  localparam int unsigned PULSE_W_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_COUNT,
    S_PULSE
  } state_e;
endpackage

// File: rtl/delay_down_counter.sv
// Loadable down-counter with zero flag; it stops at zero and never wraps.
`timescale 1ns/1ps
module delay_down_counter #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      cnt_q <= '0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/delay_ram_player.sv
// Trigger -> read delay word from RAM -> wait N cycles -> emit PULSE_W-cycle pulse.
// Build option DELAY_RAM_PLAYER_RETRIG_EN: hold one trigger that arrives while busy.
//   state   | meaning
//   S_IDLE  | waiting for I_trig
//   S_RD    | O_RD_EN high, RAM sampling O_RD_ADDR
//   S_WAIT  | RAM data arriving, counter loads it
//   S_COUNT | counting the delay down to zero
//   S_PULSE | O_pulse high, counter times the pulse width
`timescale 1ns/1ps
module delay_ram_player
  import delay_ram_player_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DELAY_W = DELAY_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF
) (
  input  logic               I_clk_10M,
  input  logic               I_rst,
  input  logic               I_trig,
  input  logic [ADDR_W-1:0]  I_wave_id,
  output logic               O_RD_EN,
  output logic [ADDR_W-1:0]  O_RD_ADDR,
  input  logic [DELAY_W-1:0] I_RD_DATA,
  output logic               O_pulse,
  output logic               O_busy,
  output logic               O_done,
  output logic               O_drop
);
  state_e               state_q;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [DELAY_W-1:0]   cnt_val;
`ifdef DELAY_RAM_PLAYER_RETRIG_EN
  logic                 pend_full_q;
  logic [ADDR_W-1:0]    pend_addr_q;
`endif

  // One counter serves both phases: delay in COUNT, pulse width in PULSE.
  always_comb begin
    cnt_load = (state_q == S_WAIT) || (state_q == S_COUNT && cnt_zero);
    cnt_val  = (state_q == S_WAIT) ? I_RD_DATA : DELAY_W'(PULSE_W - 1);
    cnt_dec  = (state_q == S_COUNT || state_q == S_PULSE) && !cnt_zero;
  end

  delay_down_counter #(.W(DELAY_W)) u_cnt (
    .clk_i      (I_clk_10M),
    .rst_i      (I_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge I_clk_10M or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= S_IDLE;
      O_RD_EN     <= 1'b0;
      O_RD_ADDR   <= '0;
      O_pulse     <= 1'b0;
      O_busy      <= 1'b0;
      O_done      <= 1'b0;
      O_drop      <= 1'b0;
`ifdef DELAY_RAM_PLAYER_RETRIG_EN
      pend_full_q <= 1'b0;
      pend_addr_q <= '0;
`endif
    end else begin
      O_done <= 1'b0;
      O_drop <= 1'b0;
      if (state_q != S_IDLE && I_trig) begin
`ifdef DELAY_RAM_PLAYER_RETRIG_EN
        if (pend_full_q) begin
          O_drop <= 1'b1;
        end else begin
          pend_full_q <= 1'b1;
          pend_addr_q <= I_wave_id;
        end
`else
        O_drop <= 1'b1;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (I_trig) begin
            state_q   <= S_RD;
            O_RD_EN   <= 1'b1;
            O_RD_ADDR <= I_wave_id;
            O_busy    <= 1'b1;
          end
        end
        S_RD: begin
          state_q <= S_WAIT;
          O_RD_EN <= 1'b0;
        end
        S_WAIT: state_q <= S_COUNT;
        S_COUNT: begin
          if (cnt_zero) begin
            state_q <= S_PULSE;
            O_pulse <= 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            O_pulse <= 1'b0;
            O_done  <= 1'b1;
`ifdef DELAY_RAM_PLAYER_RETRIG_EN
            // A trigger landing on the last pulse cycle with an empty slot launches directly.
            if (pend_full_q) begin
              state_q     <= S_RD;
              O_RD_EN     <= 1'b1;
              O_RD_ADDR   <= pend_addr_q;
              pend_full_q <= 1'b0;
            end else if (I_trig) begin
              state_q     <= S_RD;
              O_RD_EN     <= 1'b1;
              O_RD_ADDR   <= I_wave_id;
              pend_full_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              O_busy  <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            O_busy  <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
